// File: rtl/id_stage_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, ALU and muldiv
// encodings, byte-lane masks and the packed control bundle.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ARITH = 2'd0,
        ALU_LOGIC = 2'd1,
        ALU_SHIFT = 2'd2,
        ALU_CMP   = 2'd3
    } alu_type_e;

    localparam logic [1:0] AR_ADD = 2'd0, AR_ADDU = 2'd1, AR_SUB = 2'd2, AR_SUBU = 2'd3;
    localparam logic [1:0] LG_AND = 2'd0, LG_OR = 2'd1, LG_XOR = 2'd2, LG_NOR = 2'd3;
    localparam logic [1:0] SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2;
    localparam logic [1:0] CM_SLT = 2'd0, CM_SLTU = 2'd1;

    localparam logic [3:0] BYTE_B = 4'b0001;
    localparam logic [3:0] BYTE_H = 4'b0011;
    localparam logic [3:0] BYTE_W = 4'b1111;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic        writeReg;
        logic        memToReg;
        logic        writeMem;
        logic        readMem;
        alu_type_e   aluType;
        logic [1:0]  aluOp;
        logic        srcA;
        logic        srcB;
        logic        immSigned;
        logic [3:0]  byteSlct;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [2:0]  muldivOp;
    } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_dst;
    logic [4:0]        out_shamt;
    logic [15:0]       out_imm;
    logic              out_write_reg;
    logic              out_mem_to_reg;
    logic              out_write_mem;
    logic              out_read_mem;
    logic [1:0]        out_alu_type;
    logic [1:0]        out_alu_op;
    logic              out_src_a;
    logic              out_src_b;
    logic              out_imm_signed;
    logic [3:0]        out_byte_slct;
    logic              out_branch;
    logic              out_jump;
    logic              out_illegal;
    logic [2:0]        out_muldiv_op;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_shamt,
               out_imm, out_write_reg, out_mem_to_reg, out_write_mem, out_read_mem,
               out_alu_type, out_alu_op, out_src_a, out_src_b, out_imm_signed,
               out_byte_slct, out_branch, out_jump, out_illegal, out_muldiv_op
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_shamt,
               out_imm, out_write_reg, out_mem_to_reg, out_write_mem, out_read_mem,
               out_alu_type, out_alu_op, out_src_a, out_src_b, out_imm_signed,
               out_byte_slct, out_branch, out_jump, out_illegal, out_muldiv_op
    );
endinterface

// File: rtl/id_stage_decode.sv
// Combinational MIPS decoder: instruction word to control bundle plus
// which source registers the instruction actually reads.
// Optional multiply/divide decode enabled by ID_MULDIV_EN.
module inst_decode
    import mips_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        rsUsed,
    output logic        rtUsed
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       bad;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    // Opcode/funct dispatch; illegal encodings collapse to a harmless bundle.
    always_comb begin
        ctrl   = '0;
        rsUsed = 1'b1;
        rtUsed = 1'b0;
        bad    = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                rtUsed        = 1'b1;
                ctrl.writeReg = 1'b1;
                ctrl.dst      = inst[15:11];
                case (funct)
                    FN_SLL:  begin ctrl.aluType = ALU_SHIFT; ctrl.aluOp = SH_SLL; ctrl.srcA = 1'b1; rsUsed = 1'b0; end
                    FN_SRL:  begin ctrl.aluType = ALU_SHIFT; ctrl.aluOp = SH_SRL; ctrl.srcA = 1'b1; rsUsed = 1'b0; end
                    FN_SRA:  begin ctrl.aluType = ALU_SHIFT; ctrl.aluOp = SH_SRA; ctrl.srcA = 1'b1; rsUsed = 1'b0; end
                    FN_SLLV: begin ctrl.aluType = ALU_SHIFT; ctrl.aluOp = SH_SLL; end
                    FN_SRLV: begin ctrl.aluType = ALU_SHIFT; ctrl.aluOp = SH_SRL; end
                    FN_SRAV: begin ctrl.aluType = ALU_SHIFT; ctrl.aluOp = SH_SRA; end
                    FN_JR:   begin ctrl.writeReg = 1'b0; ctrl.dst = 5'd0; ctrl.jump = 1'b1; end
                    FN_ADD:  begin ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_ADD;  end
                    FN_ADDU: begin ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_ADDU; end
                    FN_SUB:  begin ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_SUB;  end
                    FN_SUBU: begin ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_SUBU; end
                    FN_AND:  begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_AND;  end
                    FN_OR:   begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_OR;   end
                    FN_XOR:  begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_XOR;  end
                    FN_NOR:  begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_NOR;  end
                    FN_SLT:  begin ctrl.aluType = ALU_CMP;   ctrl.aluOp = CM_SLT;  end
                    FN_SLTU: begin ctrl.aluType = ALU_CMP;   ctrl.aluOp = CM_SLTU; end
`ifdef ID_MULDIV_EN
                    FN_MULT:  begin ctrl.writeReg = 1'b0; ctrl.dst = 5'd0; ctrl.muldivOp = MD_MULT;  end
                    FN_MULTU: begin ctrl.writeReg = 1'b0; ctrl.dst = 5'd0; ctrl.muldivOp = MD_MULTU; end
                    FN_DIV:   begin ctrl.writeReg = 1'b0; ctrl.dst = 5'd0; ctrl.muldivOp = MD_DIV;   end
                    FN_DIVU:  begin ctrl.writeReg = 1'b0; ctrl.dst = 5'd0; ctrl.muldivOp = MD_DIVU;  end
                    FN_MFHI:  begin ctrl.muldivOp = MD_MFHI; rsUsed = 1'b0; end
                    FN_MFLO:  begin ctrl.muldivOp = MD_MFLO; rsUsed = 1'b0; end
`endif
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl.jump = 1'b1; ctrl.writeReg = 1'b1; ctrl.dst = 5'd31; rsUsed = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1; ctrl.immSigned = 1'b1; rtUsed = 1'b1;
                ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_SUBU;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.writeReg = 1'b1; ctrl.dst = inst[20:16]; ctrl.srcB = 1'b1;
                case (opcode)
                    OP_ADDI:  begin ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_ADD;  ctrl.immSigned = 1'b1; end
                    OP_ADDIU: begin ctrl.aluType = ALU_ARITH; ctrl.aluOp = AR_ADDU; ctrl.immSigned = 1'b1; end
                    OP_SLTI:  begin ctrl.aluType = ALU_CMP;   ctrl.aluOp = CM_SLT;  ctrl.immSigned = 1'b1; end
                    OP_ANDI:  begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_AND; end
                    OP_ORI:   begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_OR;  end
                    OP_XORI:  begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_XOR; end
                    default:  begin ctrl.aluType = ALU_LOGIC; ctrl.aluOp = LG_OR; rsUsed = 1'b0; end
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl.readMem = 1'b1; ctrl.memToReg = 1'b1; ctrl.writeReg = 1'b1;
                ctrl.dst = inst[20:16]; ctrl.srcB = 1'b1;
                ctrl.immSigned = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW);
                ctrl.byteSlct  = (opcode == OP_LW) ? BYTE_W :
                                 ((opcode == OP_LH) || (opcode == OP_LHU)) ? BYTE_H : BYTE_B;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.writeMem = 1'b1; ctrl.srcB = 1'b1; ctrl.immSigned = 1'b1; rtUsed = 1'b1;
                ctrl.byteSlct = (opcode == OP_SW) ? BYTE_W : (opcode == OP_SH) ? BYTE_H : BYTE_B;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl        = '0;
            ctrl.illegal = 1'b1;
            rsUsed      = 1'b0;
            rtUsed      = 1'b0;
        end
        // Writes to $0 are architecturally discarded, so never request them.
        if (ctrl.dst == 5'd0) ctrl.writeReg = 1'b0;
        ctrl.rs    = inst[25:21];
        ctrl.rt    = inst[20:16];
        ctrl.shamt = inst[10:6];
        ctrl.imm   = inst[15:0];
    end
endmodule

// File: rtl/id_stage.sv
// Registered, stallable MIPS decode stage with valid/ready on both sides,
// one-cycle load-use interlock and flush. Optional muldiv decode: ID_MULDIV_EN.
module id_stage
    import mips_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    id_stage_if.slave  bus
);
    ctrl_t           dec;
    logic            rsUsed;
    logic            rtUsed;
    ctrl_t           ctrlP1;
    logic [PC_W-1:0] pcP1;
    logic            vldP1;
    logic            ldPend;
    logic [4:0]      ldDst;
    logic            adv;
    logic            hazard;
    logic            accept;

    inst_decode uDecode (
        .inst   (bus.in_inst[31:0]),
        .ctrl   (dec),
        .rsUsed (rsUsed),
        .rtUsed (rtUsed)
    );

    // Handshake and load-use detection against the instruction being offered.
    always_comb begin
        adv    = !vldP1 || bus.out_ready;
        hazard = ldPend && (ldDst != 5'd0) &&
                 ((rsUsed && (ldDst == dec.rs)) || (rtUsed && (ldDst == dec.rt)));
        accept = bus.in_valid && adv && !hazard && !flush;
    end

    assign bus.in_ready = adv && !hazard && !flush;

    // ---- stage boundary: decode -> output register ----
    // Output register and pending-load tracker; flush outranks every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            vldP1  <= 1'b0;
            ctrlP1 <= '0;
            pcP1   <= '0;
            ldPend <= 1'b0;
            ldDst  <= '0;
        end else if (flush) begin
            vldP1  <= 1'b0;
            ldPend <= 1'b0;
        end else begin
            if (adv) vldP1 <= accept;
            if (accept) begin
                ctrlP1 <= dec;
                pcP1   <= bus.in_pc;
            end
            if (accept && dec.readMem) begin
                ldPend <= 1'b1;
                ldDst  <= dec.dst;
            end else if (bus.out_ready) begin
                ldPend <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = vldP1;
    assign bus.out_pc         = pcP1;
    assign bus.out_rs         = REG_AW'(ctrlP1.rs);
    assign bus.out_rt         = REG_AW'(ctrlP1.rt);
    assign bus.out_dst        = REG_AW'(ctrlP1.dst);
    assign bus.out_shamt      = ctrlP1.shamt;
    assign bus.out_imm        = ctrlP1.imm;
    assign bus.out_write_reg  = ctrlP1.writeReg;
    assign bus.out_mem_to_reg = ctrlP1.memToReg;
    assign bus.out_write_mem  = ctrlP1.writeMem;
    assign bus.out_read_mem   = ctrlP1.readMem;
    assign bus.out_alu_type   = ctrlP1.aluType;
    assign bus.out_alu_op     = ctrlP1.aluOp;
    assign bus.out_src_a      = ctrlP1.srcA;
    assign bus.out_src_b      = ctrlP1.srcB;
    assign bus.out_imm_signed = ctrlP1.immSigned;
    assign bus.out_byte_slct  = ctrlP1.byteSlct;
    assign bus.out_branch     = ctrlP1.branch;
    assign bus.out_jump       = ctrlP1.jump;
    assign bus.out_illegal    = ctrlP1.illegal;
    // The decoder only produces nonzero muldiv ops when ID_MULDIV_EN is defined.
    assign bus.out_muldiv_op  = ctrlP1.muldivOp;
endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage (optionally built with ID_MULDIV_EN).
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   nCmp = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    id_stage_if #(.INST_W(32), .PC_W(32), .REG_AW(5)) bus ();

    id_stage #(.INST_W(32), .PC_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        present(inst, pc);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_dst", bus.out_dst, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // addu $3,$1,$2
        issue(32'h00221821, 32'h100);
        chk("addu_valid", bus.out_valid, 1);
        chk("addu_wr", bus.out_write_reg, 1);
        chk("addu_type", bus.out_alu_type, 0);
        chk("addu_op", bus.out_alu_op, 1);
        chk("addu_dst", bus.out_dst, 3);
        chk("addu_rs_rt", {bus.out_rs, bus.out_rt}, {5'd1, 5'd2});
        chk("addu_pc", bus.out_pc, 32'h100);
        step();
        chk("idle_valid", bus.out_valid, 0);

        // lw $2,0($1) then add $3,$2,$2: lw, bubble, add
        present(32'h8C220000, 32'h200);
        step();
        chk("lw_valid", bus.out_valid, 1);
        chk("lw_rd_mem", {bus.out_read_mem, bus.out_mem_to_reg, bus.out_write_reg}, 3'b111);
        chk("lw_bytes", bus.out_byte_slct, 4'b1111);
        chk("lw_dst", bus.out_dst, 2);
        present(32'h00421820, 32'h204);
        chk("lu_in_ready", bus.in_ready, 0);
        step();
        chk("lu_bubble", bus.out_valid, 0);
        chk("lu_ready2", bus.in_ready, 1);
        step();
        chk("lu_add_valid", bus.out_valid, 1);
        chk("lu_add_pc", bus.out_pc, 32'h204);
        chk("lu_add_op", {bus.out_alu_type, bus.out_alu_op, bus.out_dst}, {2'd0, 2'd0, 5'd3});
        bus.in_valid = 1'b0;
        step();

        // ori $5,$0,0xFFFF held under back-pressure
        bus.out_ready = 1'b0;
        present(32'h3405FFFF, 32'h300);
        step();
        chk("ori_valid", bus.out_valid, 1);
        chk("ori_ext", {bus.out_imm_signed, bus.out_src_b}, 2'b01);
        chk("ori_alu", {bus.out_alu_type, bus.out_alu_op}, {2'd1, 2'd1});
        present(32'h38A61234, 32'h304);
        for (int i = 0; i < 3; i++) begin
            chk("hold_in_ready", bus.in_ready, 0);
            step();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_fields", {bus.out_imm, bus.out_dst, bus.out_pc[15:0]}, {16'hFFFF, 5'd5, 16'h0300});
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", bus.in_ready, 1);
        step();
        chk("xori_fields", {bus.out_imm, bus.out_dst, bus.out_alu_op, bus.out_imm_signed}, {16'h1234, 5'd6, 2'd2, 1'b0});

        // sw $2,4($1) in the output register, then flush with addu presented
        present(32'hAC220004, 32'h400);
        step();
        chk("sw_ctrl", {bus.out_write_mem, bus.out_write_reg, bus.out_read_mem}, 3'b100);
        chk("sw_ext", {bus.out_byte_slct, bus.out_imm_signed, bus.out_src_b}, {4'b1111, 2'b11});
        flush = 1'b1;
        present(32'h00221821, 32'h404);
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid", bus.out_valid, 0);
        chk("post_flush_ready", bus.in_ready, 1);
        step();
        chk("post_flush_pc", bus.out_pc, 32'h404);
        bus.in_valid = 1'b0;
        step();

        // Flush drops the pending-load interlock
        issue(32'h8C220000, 32'h500);
        bus.out_ready = 1'b0;
        flush = 1'b1;
        present(32'h00421820, 32'h504);
        step();
        flush = 1'b0;
        #1;
        chk("flush_ldpend", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Illegal opcode 0x3F
        issue(32'hFC000000, 32'h600);
        chk("ill_flag", bus.out_illegal, 1);
        chk("ill_enables", {bus.out_write_reg, bus.out_write_mem, bus.out_read_mem,
                            bus.out_branch, bus.out_jump}, 5'b0);

        // mult $1,$2
        issue(32'h00220018, 32'h604);
`ifdef ID_MULDIV_EN
        chk("mult_op", bus.out_muldiv_op, 1);
        chk("mult_ill", {bus.out_illegal, bus.out_write_reg}, 2'b00);
`else
        chk("mult_ill", bus.out_illegal, 1);
        chk("mult_op", bus.out_muldiv_op, 0);
`endif

        // jal, beq, addu to $0, lbu
        issue(32'h0C000010, 32'h608);
        chk("jal", {bus.out_jump, bus.out_write_reg, bus.out_dst}, {2'b11, 5'd31});
        issue(32'h10220003, 32'h60C);
        chk("beq", {bus.out_branch, bus.out_write_reg, bus.out_imm_signed}, 3'b101);
        issue(32'h00220021, 32'h610);
        chk("wr_zero", {bus.out_write_reg, bus.out_illegal}, 2'b00);
        issue(32'h90220000, 32'h614);
        chk("lbu", {bus.out_byte_slct, bus.out_imm_signed, bus.out_read_mem}, {4'b0001, 2'b01});

        // Reset while stalled
        bus.out_ready = 1'b0;
        step();
        issue(32'h00221821, 32'h700);
        step();
        chk("stall_valid", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_fields", {bus.out_dst, bus.out_pc}, 37'd0);
        bus.out_ready = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
